mem_bus_master: RTL

Shared Wishbone master for the five-stage pipeline. It serves instruction fetches from IF and loads/stores from MEM over one bus port. It generates the `im` and `mem` stall requests consumed by the pipeline stall/flush controller, so it is the producer side of that stall interface. MEM accesses take priority over fetches.

---
 rtl/mem_bus_master_if.sv | 37 +++
 rtl/mem_bus_master.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_bus_master_if.sv
// -----------------------------------------------------------------------------
// mem_bus_master_if
// Wishbone classic single-transfer bus between the pipeline's shared memory
// master and the memory/peripheral slave.
//
// Signals (named from the master's point of view):
//   wb_cyc_o, wb_stb_o  master -> slave  cycle / strobe (always equal)
//   wb_we_o             master -> slave  1 = write
//   wb_adr_o            master -> slave  address, ADDR_WIDTH bits
//   wb_dat_o            master -> slave  write data, DATA_WIDTH bits
//   wb_sel_o            master -> slave  byte selects, DATA_WIDTH/8 bits
//   wb_dat_i            slave -> master  read data, DATA_WIDTH bits
//   wb_ack_i            slave -> master  transfer acknowledge
// -----------------------------------------------------------------------------
interface mem_bus_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      wb_cyc_o;
    logic                      wb_stb_o;
    logic                      wb_we_o;
    logic [ADDR_WIDTH-1:0]     wb_adr_o;
    logic [DATA_WIDTH-1:0]     wb_dat_o;
    logic [DATA_WIDTH/8-1:0]   wb_sel_o;
    logic [DATA_WIDTH-1:0]     wb_dat_i;
    logic                      wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/mem_bus_master.sv
// -----------------------------------------------------------------------------
// mem_bus_master
// Shared Wishbone master for the five-stage pipeline. Serves instruction
// fetches (IF) and loads/stores (MEM) over one bus port, MEM first, and
// produces the im/mem stall requests for the stall/flush controller.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   if_req, if_addr            fetch request and PC
//   if_rdata, if_stall         registered instruction, fetch-not-served stall
//   pc_stall, flush            PC stall bit and branch flush from the pipeline
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_sel         MEM-stage access
//   mem_rdata, mem_stall       registered load data, access-not-served stall
//   wb                         Wishbone master port (mem_bus_master_if.master)
//
// State | Meaning
// ------+--------------------------------------------------------------
// IDLE  | no bus cycle; arbitrate MEM over IF and launch the next cycle
// IF_BUS| instruction fetch on the bus, waiting for ack
// MEM_BUS| load/store on the bus, waiting for ack
// -----------------------------------------------------------------------------
module mem_bus_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_stall,
    input  logic                    pc_stall,
    input  logic                    flush,
    input  logic                    mem_req,
    input  logic                    mem_we,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_sel,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_stall,
    mem_bus_master_if.master        wb
);

    localparam int SEL_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUS  = 2'd1,
        MEM_BUS = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    cyc_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [SEL_W-1:0]        sel_q;
    logic [DATA_WIDTH-1:0]   if_rdata_q;
    logic [DATA_WIDTH-1:0]   mem_rdata_q;
    logic                    if_done_q;
    logic                    mem_done_q;
    logic                    if_kill_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_kill_q   <= 1'b0;
        end else begin
            // The pipeline advances in the cycle mem_done is seen, so it only
            // ever lives for one cycle.
            mem_done_q <= 1'b0;
            // A completed fetch is held until the PC actually moves (or is
            // redirected), so a stall from elsewhere never causes a refetch.
            if (!pc_stall || flush) begin
                if_done_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (mem_req && !mem_done_q) begin
                        state_q <= MEM_BUS;
                        cyc_q   <= 1'b1;
                        we_q    <= mem_we;
                        adr_q   <= mem_addr;
                        dat_q   <= mem_wdata;
                        sel_q   <= mem_sel;
                    end else if (if_req && !if_done_q && !flush) begin
                        state_q <= IF_BUS;
                        cyc_q   <= 1'b1;
                        we_q    <= 1'b0;
                        adr_q   <= if_addr;
                        dat_q   <= '0;
                        sel_q   <= '1;
                    end
                end

                IF_BUS: begin
                    if (wb.wb_ack_i) begin
                        state_q <= IDLE;
                        cyc_q   <= 1'b0;
                        // A flush arriving with the ack kills the result too.
                        if (!if_kill_q && !flush) begin
                            if_rdata_q <= wb.wb_dat_i;
                            if_done_q  <= 1'b1;
                        end
                        if_kill_q <= 1'b0;
                    end else if (flush) begin
                        if_kill_q <= 1'b1;
                    end
                end

                MEM_BUS: begin
                    if (wb.wb_ack_i) begin
                        state_q    <= IDLE;
                        cyc_q      <= 1'b0;
                        mem_done_q <= 1'b1;
                        if (!we_q) begin
                            mem_rdata_q <= wb.wb_dat_i;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cyc_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = sel_q;

    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_stall  = if_req & ~if_done_q;
    assign mem_stall = mem_req & ~mem_done_q;

endmodule
